aes_round_sequencer: RTL and testbench

AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

---
 rtl/aes_round_sequencer.sv | 141 ++++++++++++++
 tb/tb_aes_round_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// AES encryption round sequencer. Keeps the 128-bit cipher state and round
// count, fetches round keys by index, and sends each round's SubBytes to an
// external S-box unit over a valid/ready request and a valid-only response.
// ShiftRows, MixColumns and AddRoundKey are applied here when the response
// comes back. Column c of a 128-bit block is [127-32c -: 32], and row 0 of
// each column is its top byte.

// One column of MixColumns: each output byte is a [2 3 1 1] rotation over GF(2^8).
module aes_round_sequencer_mixcol (
  input  logic [31:0] a,
  output logic [31:0] y
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] b0, b1, b2, b3;
  assign {b0, b1, b2, b3} = a;

  assign y[31:24] = xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3;
  assign y[23:16] = b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3;
  assign y[15:8]  = b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3;
  assign y[7:0]   = xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3);
endmodule

module aes_round_sequencer #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         sb_req_valid,
  input  logic         sb_req_ready,
  output logic [127:0] sb_req_data,
  input  logic         sb_rsp_valid,
  input  logic [127:0] sb_rsp_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int NCOL = 4;

  // Only the three AES key sizes have a defined round count.
  if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
    $error("aes_round_sequencer: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR4 = 4'(NR);

  typedef enum logic [1:0] {IDLE, SB_REQ, SB_WAIT, DONE} st_t;

  st_t          st;
  logic [3:0]   rnd;
  logic [127:0] state_q;
  logic [127:0] out_q;
  logic         in_rdy_q, sbv_q, ov_q, busy_q;
  logic [3:0]   rk_q;

  logic [127:0] sr, mc, rnd_res;

  // ShiftRows is a fixed byte permutation. MixColumns uses one instance per column.
  for (genvar c = 0; c < NCOL; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[127-32*c-8*r -: 8] = sb_rsp_data[127-32*((c+r)%NCOL)-8*r -: 8];
    end
    aes_round_sequencer_mixcol u_mc (
      .a (sr[127-32*c -: 32]),
      .y (mc[127-32*c -: 32])
    );
  end

  // The last round skips MixColumns.
  assign rnd_res = ((rnd < NR4) ? mc : sr) ^ rk_data;

  // Round FSM. The handshake flags and the key index are registered and
  // updated on every transition. in_ready is also held low while rst is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      rnd      <= 4'd0;
      state_q  <= '0;
      out_q    <= '0;
      in_rdy_q <= 1'b1;
      sbv_q    <= 1'b0;
      ov_q     <= 1'b0;
      busy_q   <= 1'b0;
      rk_q     <= 4'd0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          state_q  <= in_data ^ rk_data;
          rnd      <= 4'd1;
          rk_q     <= 4'd1;
          st       <= SB_REQ;
          in_rdy_q <= 1'b0;
          sbv_q    <= 1'b1;
          busy_q   <= 1'b1;
        end
        SB_REQ: if (sb_req_ready) begin
          st    <= SB_WAIT;
          sbv_q <= 1'b0;
        end
        SB_WAIT: if (sb_rsp_valid) begin
          if (rnd < NR4) begin
            state_q <= rnd_res;
            rnd     <= rnd + 4'd1;
            rk_q    <= rnd + 4'd1;
            st      <= SB_REQ;
            sbv_q   <= 1'b1;
          end else begin
            out_q <= rnd_res;
            rk_q  <= NR4;
            st    <= DONE;
            ov_q  <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          st       <= IDLE;
          rk_q     <= 4'd0;
          ov_q     <= 1'b0;
          in_rdy_q <= 1'b1;
          busy_q   <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign in_ready     = in_rdy_q & ~rst;
  assign rk_idx       = rk_q;
  assign sb_req_valid = sbv_q;
  assign sb_req_data  = state_q;
  assign out_valid    = ov_q;
  assign out_data     = out_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer. Instance 0 is AES-128 (NR=10) and
// instance 1 is AES-256 (NR=14). The bench builds its own S-box and round keys.
// An S-box responder with adjustable stalls and delays runs once per cycle
// inside tick().
module tb_aes_round_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] in_valid, in_ready, sb_req_valid, sb_req_ready, sb_rsp_valid;
  logic [1:0] out_valid, out_ready, busy;
  logic [127:0] in_data [2];
  logic [127:0] sb_req_data [2];
  logic [127:0] sb_rsp_data [2];
  logic [127:0] out_data [2];
  logic [127:0] rk_data [2];
  logic [3:0]   rk_idx [2];

  logic [127:0] rkt [2][16];
  logic [7:0]   sbt [256];

  // S-box responder state. inj_* lets the bench force an unsolicited response.
  logic [1:0]   mv, pend, inj_v;
  logic [127:0] md [2];
  logic [127:0] q [2];
  logic [127:0] inj_d [2];
  int           cnt [2];
  int           dly [2];      // < 0 : random 0..5 cycles
  int           rdy_mode [2]; // 0 always ready, 1 random stalls, 2 never ready

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] K128_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K256_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] K128_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;

  always #5 clk = ~clk;

  assign rk_data[0]     = rkt[0][rk_idx[0]];
  assign rk_data[1]     = rkt[1][rk_idx[1]];
  assign sb_rsp_valid   = mv | inj_v;
  assign sb_rsp_data[0] = inj_v[0] ? inj_d[0] : md[0];
  assign sb_rsp_data[1] = inj_v[1] ? inj_d[1] : md[1];

  aes_round_sequencer #(.NR(10)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .rk_idx(rk_idx[0]), .rk_data(rk_data[0]),
    .sb_req_valid(sb_req_valid[0]), .sb_req_ready(sb_req_ready[0]), .sb_req_data(sb_req_data[0]),
    .sb_rsp_valid(sb_rsp_valid[0]), .sb_rsp_data(sb_rsp_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0])
  );

  aes_round_sequencer #(.NR(14)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .rk_idx(rk_idx[1]), .rk_data(rk_data[1]),
    .sb_req_valid(sb_req_valid[1]), .sb_req_ready(sb_req_ready[1]), .sb_req_data(sb_req_data[1]),
    .sb_rsp_valid(sb_rsp_valid[1]), .sb_rsp_data(sb_rsp_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1])
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box entry: multiplicative inverse (x^254), then the affine transform.
  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
  endfunction

  function automatic logic [127:0] subst(input logic [127:0] x);
    logic [127:0] y;
    for (int k = 0; k < 16; k++) y[8*k +: 8] = sbt[x[8*k +: 8]];
    return y;
  endfunction

  // FIPS-197 key expansion into rkt[id]. The key is left-aligned in 256 bits.
  task automatic key_exp(input int id, input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) rkt[id][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         rkt[id][r] = '0;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {in_ready, out_valid, sb_req_valid, busy, rk_idx}
  function automatic logic [7:0] flags(input int i);
    return {in_ready[i], out_valid[i], sb_req_valid[i], busy[i], rk_idx[i]};
  endfunction

  // Advance to the next falling edge, then run one cycle of the S-box responder.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0;
      if (pend[i]) begin
        if (cnt[i] == 0) begin
          mv[i]   = 1'b1;
          md[i]   = subst(q[i]);
          pend[i] = 1'b0;
        end else begin
          cnt[i]--;
        end
      end
      case (rdy_mode[i])
        0:       sb_req_ready[i] = 1'b1;
        1:       sb_req_ready[i] = ($urandom_range(0, 2) != 0);
        default: sb_req_ready[i] = 1'b0;
      endcase
      if (sb_req_valid[i] && sb_req_ready[i]) begin
        pend[i] = 1'b1;
        cnt[i]  = (dly[i] < 0) ? int'($urandom_range(0, 5)) : dly[i];
        q[i]    = sb_req_data[i];
      end
    end
  endtask

  // Call this on the falling edge right after the accepting edge. The count
  // starts at 1 there, so it equals the number of cycles from the accept cycle
  // to the first cycle with out_valid high.
  task automatic wait_out(input int i, input string tag, input logic [127:0] exp_ct, input int exp_lat);
    int lat = 1;
    while (!out_valid[i] && lat < 3000) begin
      tick();
      lat++;
    end
    chk({tag, "_valid"}, 128'(out_valid[i]), 128'(1));
    if (exp_lat > 0) chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_ct"}, out_data[i], exp_ct);
  endtask

  task automatic enc(input int i, input logic [127:0] pt, input logic [127:0] exp_ct,
                     input string tag, input int exp_lat);
    int n = 0;
    in_data[i]  = pt;
    in_valid[i] = 1'b1;
    while (!in_ready[i] && n < 100) begin
      tick();
      n++;
    end
    tick();
    in_valid[i] = 1'b0;
    wait_out(i, tag, exp_ct, exp_lat);
  endtask

  task automatic drain(input int i, input string tag);
    out_ready[i] = 1'b1;
    tick();
    out_ready[i] = 1'b0;
    chk(tag, 128'({out_valid[i], in_ready[i], busy[i]}), 128'(3'b010));
  endtask

  initial begin
    int n;
    logic found;
    rst = 1'b1;
    in_valid = '0; out_ready = '0; sb_req_ready = '1;
    mv = '0; pend = '0; inj_v = '0;
    for (int i = 0; i < 2; i++) begin
      in_data[i] = '0; md[i] = '0; q[i] = '0; inj_d[i] = '0;
      cnt[i] = 0; dly[i] = 0; rdy_mode[i] = 0;
      for (int r = 0; r < 16; r++) rkt[i][r] = '0;
    end
    for (int b = 0; b < 256; b++) sbt[b] = sbox_f(8'(b));

    // Reset: while rst is high and one cycle after it drops.
    tick(); tick();
    chk("rst_flags0", 128'(flags(0)), 128'(8'h00));
    chk("rst_flags1", 128'(flags(1)), 128'(8'h00));
    chk("rst_out0", out_data[0], '0);
    rst = 1'b0;
    tick();
    chk("post_rst_flags0", 128'(flags(0)), 128'(8'h80));
    chk("post_rst_flags1", 128'(flags(1)), 128'(8'h80));

    // FIPS-197 C.1 (AES-128) and C.3 (AES-256) with a one-cycle S-box.
    key_exp(0, {K128_C1, 128'h0}, 4, 10);
    enc(0, PT_C1, CT_C1, "c1", 21);
    drain(0, "c1_drain");
    key_exp(1, K256_C3, 8, 14);
    enc(1, PT_C1, CT_C3, "c3", 29);
    drain(1, "c3_drain");

    // Hold DONE for 10 cycles with in_valid pulsing, then hand off back to back.
    enc(0, PT_C1, CT_C1, "hold", 21);
    for (int k = 0; k < 10; k++) begin
      in_valid[0] = k[0];
      tick();
      chk("hold_flags", 128'({out_valid[0], in_ready[0], rk_idx[0]}), 128'(6'b10_1010));
      chk("hold_data", out_data[0], CT_C1);
    end
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    chk("handoff_idle", 128'({out_valid[0], in_ready[0]}), 128'(2'b01));
    tick();
    in_valid[0] = 1'b0;
    chk("handoff_accept", 128'(flags(0)), 128'(8'h31));
    wait_out(0, "handoff", CT_C1, 21);
    drain(0, "handoff_drain");

    // FIPS-197 Appendix B with random request stalls and 0-5 cycle responses.
    key_exp(0, {K128_B, 128'h0}, 4, 10);
    rdy_mode[0] = 1; dly[0] = -1;
    enc(0, PT_B, CT_B, "fipsb_rand", -1);
    drain(0, "fipsb_drain");
    enc(0, PT_B, CT_B, "fipsb_rand2", -1);
    drain(0, "fipsb_drain2");
    rdy_mode[0] = 0; dly[0] = 0;

    // An unsolicited response in IDLE changes nothing.
    inj_v[0] = 1'b1; inj_d[0] = {$urandom, $urandom, $urandom, $urandom};
    tick();
    inj_v[0] = 1'b0;
    chk("inj_idle_flags", 128'(flags(0)), 128'(8'h80));
    chk("inj_idle_out", out_data[0], CT_B);

    // An unsolicited response in SB_REQ changes nothing. The request is held by stalling.
    rdy_mode[0] = 2;
    in_data[0] = PT_B; in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    inj_v[0] = 1'b1; inj_d[0] = {$urandom, $urandom, $urandom, $urandom};
    tick();
    inj_v[0] = 1'b0;
    chk("inj_req_flags", 128'(flags(0)), 128'(8'h31));
    chk("inj_req_data", sb_req_data[0], PT_B ^ rkt[0][0]);
    tick();
    chk("req_stable", sb_req_data[0], PT_B ^ rkt[0][0]);
    rdy_mode[0] = 0;
    wait_out(0, "inj_req", CT_B, -1);
    drain(0, "inj_req_drain");

    // Reset in SB_WAIT of round 5, then an orphan response after the reset.
    dly[0] = 5;
    in_data[0] = PT_B; in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 500) begin
      found = busy[0] && !sb_req_valid[0] && !out_valid[0] && rk_idx[0] == 4'd5;
      if (!found) tick();
      n++;
    end
    chk("reach_rnd5_wait", 128'(found), 128'(1));
    rst = 1'b1;
    tick();
    chk("midrst_flags", 128'(flags(0)), 128'(8'h00));
    chk("midrst_out", out_data[0], '0);
    rst = 1'b0;
    pend[0] = 1'b0; dly[0] = 0;
    tick();
    chk("midrst_post", 128'(flags(0)), 128'(8'h80));
    inj_v[0] = 1'b1; inj_d[0] = subst(PT_B);
    tick();
    inj_v[0] = 1'b0;
    chk("orphan_flags", 128'(flags(0)), 128'(8'h80));
    chk("orphan_out", out_data[0], '0);
    enc(0, PT_B, CT_B, "after_rst", 21);
    drain(0, "after_rst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
